// File: rtl/stage_sequencer.sv
// Multicycle fetch/decode/exec/mem/wb control FSM with PC steering, write-enable and retire count.
// Latency: NOP/HALT 2, JUMP/BRANCH/ALU 3, ALU-WB 4, STORE 4, LOAD 5 cycles plus memory waits.
// Backpressure: stalls in FETCH/MEM until MEM_READY; MEM_TIMEOUT consecutive misses set ERR and halt.
module stage_sequencer #(
    parameter int MEM_TIMEOUT = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  OPCD_IN,
    input  logic        OPT_BIT_IN,
    input  logic        COND_IN,
    input  logic        MEM_READY,
    output logic        EN_FETCH,
    output logic        EN_DECODE,
    output logic        EN_EXEC,
    output logic        EN_MEM,
    output logic        EN_WB,
    output logic        PC_WR,
    output logic        PC_SRC,
    output logic        REG_WE,
    output logic        RETIRE,
    output logic [15:0] INSTR_CNT,
    output logic        ERR,
    output logic [2:0]  ESTADO
);

    localparam logic [4:0] OP_NOP    = 5'd0;
    localparam logic [4:0] OP_LOAD   = 5'd20;
    localparam logic [4:0] OP_STORE  = 5'd21;
    localparam logic [4:0] OP_JUMP   = 5'd22;
    localparam logic [4:0] OP_BRANCH = 5'd23;
    localparam logic [4:0] OP_HALT   = 5'd31;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  op_q;
    logic        opt_q;
    logic [7:0]  wait_q;
    logic [15:0] cnt_q;
    logic        err_q;

    logic        latch;
    logic        timeout;
    logic        taken;

    always_comb begin
        state_d   = state_q;
        EN_FETCH  = 1'b0;
        EN_DECODE = 1'b0;
        EN_EXEC   = 1'b0;
        EN_MEM    = 1'b0;
        EN_WB     = 1'b0;
        PC_WR     = 1'b0;
        PC_SRC    = 1'b0;
        REG_WE    = 1'b0;
        RETIRE    = 1'b0;
        latch     = 1'b0;
        timeout   = 1'b0;
        taken     = (op_q == OP_JUMP) || ((op_q == OP_BRANCH) && COND_IN);

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                EN_FETCH = 1'b1;
                if (MEM_READY) begin
                    latch   = 1'b1;
                    PC_WR   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                EN_DECODE = 1'b1;
                if (op_q == OP_NOP) begin
                    RETIRE  = 1'b1;
                    state_d = S_FETCH;
                end else if (op_q == OP_HALT) begin
                    RETIRE  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                EN_EXEC = 1'b1;
                PC_WR   = taken;
                PC_SRC  = taken;
                if ((op_q == OP_JUMP) || (op_q == OP_BRANCH)) begin
                    RETIRE  = 1'b1;
                    state_d = S_FETCH;
                end else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
                    state_d = S_MEM;
                end else if (opt_q) begin
                    state_d = S_WB;
                end else begin
                    RETIRE  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                EN_MEM = 1'b1;
                if (MEM_READY) begin
                    if (op_q == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        RETIRE  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                EN_WB   = 1'b1;
                REG_WE  = 1'b1;
                RETIRE  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Wait counter only runs while stalled; any other cycle leaves it at zero,
    // so it is already clear on every entry to FETCH or MEM.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            op_q    <= 5'd0;
            opt_q   <= 1'b0;
            wait_q  <= 8'd0;
            cnt_q   <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                op_q  <= OPCD_IN;
                opt_q <= OPT_BIT_IN;
            end
            if (((state_q == S_FETCH) || (state_q == S_MEM)) && !MEM_READY) begin
                wait_q <= wait_q + 8'd1;
            end else begin
                wait_q <= 8'd0;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
            if (RETIRE) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign INSTR_CNT = cnt_q;
    assign ERR       = err_q;
    assign ESTADO    = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: drives inputs on the falling edge and checks 1 ns later.
module tb_stage_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  OPCD_IN;
    logic        OPT_BIT_IN;
    logic        COND_IN;
    logic        MEM_READY;
    logic        EN_FETCH, EN_DECODE, EN_EXEC, EN_MEM, EN_WB;
    logic        PC_WR, PC_SRC, REG_WE, RETIRE;
    logic [15:0] INSTR_CNT;
    logic        ERR;
    logic [2:0]  ESTADO;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    // Output vector bit positions: F D E M W PW PS WE RT
    localparam logic [8:0] B_F  = 9'h100;
    localparam logic [8:0] B_D  = 9'h080;
    localparam logic [8:0] B_E  = 9'h040;
    localparam logic [8:0] B_M  = 9'h020;
    localparam logic [8:0] B_W  = 9'h010;
    localparam logic [8:0] B_PW = 9'h008;
    localparam logic [8:0] B_PS = 9'h004;
    localparam logic [8:0] B_WE = 9'h002;
    localparam logic [8:0] B_RT = 9'h001;

    stage_sequencer #(.MEM_TIMEOUT(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .OPCD_IN    (OPCD_IN),
        .OPT_BIT_IN (OPT_BIT_IN),
        .COND_IN    (COND_IN),
        .MEM_READY  (MEM_READY),
        .EN_FETCH   (EN_FETCH),
        .EN_DECODE  (EN_DECODE),
        .EN_EXEC    (EN_EXEC),
        .EN_MEM     (EN_MEM),
        .EN_WB      (EN_WB),
        .PC_WR      (PC_WR),
        .PC_SRC     (PC_SRC),
        .REG_WE     (REG_WE),
        .RETIRE     (RETIRE),
        .INSTR_CNT  (INSTR_CNT),
        .ERR        (ERR),
        .ESTADO     (ESTADO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [2:0] st, input logic [8:0] outs);
        logic [8:0] vec;
        vec = {EN_FETCH, EN_DECODE, EN_EXEC, EN_MEM, EN_WB, PC_WR, PC_SRC, REG_WE, RETIRE};
        check(tag, {20'd0, st == ESTADO ? st : ESTADO, vec}, {20'd0, st, outs});
    endtask

    task automatic cyc(input logic r, input logic [4:0] op, input logic opt, input logic c);
        @(negedge CLK);
        MEM_READY  = r;
        OPCD_IN    = op;
        OPT_BIT_IN = opt;
        COND_IN    = c;
        #1;
    endtask

    task automatic retire_seen;
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    endtask

    initial begin
        RST = 1'b0; MEM_READY = 1'b0; OPCD_IN = 5'd0; OPT_BIT_IN = 1'b0; COND_IN = 1'b0;
        #3;
        expect_st("reset_outs", 3'd0, 9'd0);
        check("reset_cnt", 32'(INSTR_CNT), 32'd0);
        check("reset_err", 32'(ERR), 32'd0);

        @(negedge CLK); RST = 1'b1; #1;
        expect_st("idle", 3'd0, 9'd0);

        // Two NOPs: FETCH/DECODE alternate, retire every second cycle
        cyc(1, 5'd0, 0, 0); expect_st("nop1_fetch", 3'd1, B_F | B_PW);
        cyc(1, 5'd0, 0, 0); expect_st("nop1_dec", 3'd2, B_D | B_RT); retire_seen();
        cyc(1, 5'd0, 0, 0); expect_st("nop2_fetch", 3'd1, B_F | B_PW);
        check("cnt_nop1", 32'(INSTR_CNT), 32'(exp_cnt));
        cyc(1, 5'd0, 0, 0); expect_st("nop2_dec", 3'd2, B_D | B_RT); retire_seen();

        // ALU with writeback; opcode input changes after fetch to prove latching
        cyc(1, 5'd3, 1, 0); expect_st("alu_fetch", 3'd1, B_F | B_PW);
        check("cnt_nop2", 32'(INSTR_CNT), 32'(exp_cnt));
        cyc(1, 5'd0, 0, 0); expect_st("alu_dec", 3'd2, B_D);
        cyc(1, 5'd0, 0, 0); expect_st("alu_exec", 3'd3, B_E);
        cyc(1, 5'd0, 0, 0); expect_st("alu_wb", 3'd5, B_W | B_WE | B_RT); retire_seen();

        // LOAD with three not-ready cycles in MEM: 8 cycles total
        cyc(1, 5'd20, 0, 0); expect_st("ld_fetch", 3'd1, B_F | B_PW);
        check("cnt_alu", 32'(INSTR_CNT), 32'(exp_cnt));
        cyc(1, 5'd0, 0, 0); expect_st("ld_dec", 3'd2, B_D);
        cyc(1, 5'd0, 0, 0); expect_st("ld_exec", 3'd3, B_E);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 5'd0, 0, 0); expect_st($sformatf("ld_mem_wait%0d", i), 3'd4, B_M);
        end
        cyc(1, 5'd0, 0, 0); expect_st("ld_mem_rdy", 3'd4, B_M);
        cyc(1, 5'd0, 0, 0); expect_st("ld_wb", 3'd5, B_W | B_WE | B_RT); retire_seen();

        // Branch taken, branch not taken, jump
        cyc(1, 5'd23, 0, 0); expect_st("br1_fetch", 3'd1, B_F | B_PW);
        check("cnt_load", 32'(INSTR_CNT), 32'(exp_cnt));
        cyc(1, 5'd0, 0, 0); expect_st("br1_dec", 3'd2, B_D);
        cyc(1, 5'd0, 0, 1); expect_st("br1_exec_taken", 3'd3, B_E | B_PW | B_PS | B_RT); retire_seen();
        cyc(1, 5'd23, 0, 0); expect_st("br0_fetch", 3'd1, B_F | B_PW);
        cyc(1, 5'd0, 0, 1); expect_st("br0_dec", 3'd2, B_D);
        cyc(1, 5'd0, 0, 0); expect_st("br0_exec_nt", 3'd3, B_E | B_RT); retire_seen();
        cyc(1, 5'd22, 0, 0); expect_st("jmp_fetch", 3'd1, B_F | B_PW);
        cyc(1, 5'd0, 0, 0); expect_st("jmp_dec", 3'd2, B_D);
        cyc(1, 5'd0, 0, 0); expect_st("jmp_exec", 3'd3, B_E | B_PW | B_PS | B_RT); retire_seen();

        // STORE retires in MEM without writeback
        cyc(1, 5'd21, 1, 0); expect_st("st_fetch", 3'd1, B_F | B_PW);
        cyc(1, 5'd0, 0, 0); expect_st("st_dec", 3'd2, B_D);
        cyc(1, 5'd0, 0, 0); expect_st("st_exec", 3'd3, B_E);
        cyc(1, 5'd0, 0, 0); expect_st("st_mem", 3'd4, B_M | B_RT); retire_seen();

        // ALU without writeback retires in EXEC
        cyc(1, 5'd3, 0, 0); expect_st("alu0_fetch", 3'd1, B_F | B_PW);
        check("cnt_store", 32'(INSTR_CNT), 32'(exp_cnt));
        cyc(1, 5'd0, 1, 0); expect_st("alu0_dec", 3'd2, B_D);
        cyc(1, 5'd0, 1, 0); expect_st("alu0_exec", 3'd3, B_E | B_RT); retire_seen();

        // Ready arriving on the 8th stalled cycle wins over the timeout
        for (int i = 0; i < 7; i++) begin
            cyc(0, 5'd0, 0, 0); expect_st($sformatf("edge_wait%0d", i), 3'd1, B_F);
        end
        cyc(1, 5'd0, 0, 0); expect_st("edge_rdy", 3'd1, B_F | B_PW);
        cyc(1, 5'd0, 0, 0); expect_st("edge_dec", 3'd2, B_D | B_RT); retire_seen();
        check("edge_err", 32'(ERR), 32'd0);

        // Counter wrap: preload 16'hFFFF, next retire goes to 0
        cyc(1, 5'd0, 0, 0);
        check("cnt_pre_wrap", 32'(INSTR_CNT), 32'(exp_cnt));
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        exp_cnt = 16'hFFFF;
        cyc(1, 5'd0, 0, 0); expect_st("wrap_dec", 3'd2, B_D | B_RT); retire_seen();
        cyc(1, 5'd0, 0, 0); check("cnt_wrap0", 32'(INSTR_CNT), 32'd0);
        cyc(1, 5'd0, 0, 0); retire_seen();
        cyc(1, 5'd31, 0, 0); check("cnt_wrap1", 32'(INSTR_CNT), 32'd1);

        // HALT retires and absorbs
        cyc(1, 5'd0, 0, 0); expect_st("halt_dec", 3'd2, B_D | B_RT); retire_seen();
        cyc(1, 5'd0, 0, 0); expect_st("halt0", 3'd6, 9'd0);
        check("cnt_halt", 32'(INSTR_CNT), 32'(exp_cnt));
        cyc(1, 5'd3, 1, 1); expect_st("halt1", 3'd6, 9'd0);
        cyc(0, 5'd0, 0, 0); expect_st("halt2", 3'd6, 9'd0);
        check("halt_err", 32'(ERR), 32'd0);

        // Reset asserted mid-MEM clears everything immediately
        RST = 1'b0; #1;
        expect_st("rst_from_halt", 3'd0, 9'd0);
        @(negedge CLK); RST = 1'b1;
        cyc(1, 5'd20, 0, 0); expect_st("rm_fetch", 3'd1, B_F | B_PW);
        cyc(1, 5'd0, 0, 0); expect_st("rm_dec", 3'd2, B_D);
        cyc(1, 5'd0, 0, 0); expect_st("rm_exec", 3'd3, B_E);
        cyc(0, 5'd0, 0, 0); expect_st("rm_mem", 3'd4, B_M);
        #2; RST = 1'b0; #1;
        expect_st("rm_reset", 3'd0, 9'd0);
        check("rm_cnt", 32'(INSTR_CNT), 32'd0);

        // Fetch timeout: 8 stalled cycles, then sticky ERR in HALT
        @(negedge CLK); RST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 5'd0, 0, 0); expect_st($sformatf("to_wait%0d", i), 3'd1, B_F);
            check($sformatf("to_err_low%0d", i), 32'(ERR), 32'd0);
        end
        cyc(1, 5'd0, 0, 0); expect_st("to_halt", 3'd6, 9'd0);
        check("to_err", 32'(ERR), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 5'd0, 0, 0);
            check($sformatf("to_sticky%0d", i), {29'd0, ESTADO}, 32'd6);
            check($sformatf("to_err_sticky%0d", i), 32'(ERR), 32'd1);
        end
        RST = 1'b0; #1;
        check("to_err_cleared", 32'(ERR), 32'd0);
        expect_st("to_reset", 3'd0, 9'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
